// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable synchronous down-counter with a one-cycle
// terminal-count pulse and IDLE/RUN/DONE state machine.
// Optional feature macro: AUTO_RELOAD_EN (periodic reload on expiry instead
// of stopping in DONE).
module sync_down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state and datapath: clr beats load, load beats counting
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (clr) begin
            state_d = IDLE;
            q_d     = '0;
        end else if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            // A zero load has nothing to count, so it parks in IDLE
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        if (q_q > WIDTH'(1)) begin
                            q_d = q_q - WIDTH'(1);
                        end else if (q_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            q_d     = reload_q;
                            state_d = RUN;
`else
                            q_d     = '0;
                            state_d = DONE;
`endif
                        end else begin
                            // Unreachable in normal use; never decrement through zero
                            state_d = IDLE;
                        end
                    end
                end
                DONE:    state_d = DONE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs come straight from flops or a direct decode of the state flop
    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
